// File: rtl/lcd_host.sv
// Host-side driver for the LCD image controller: IROM responder, queued command
// issue, and IRAM write-back capture into a readable frame buffer.
//
// state      | meaning
// IDLE       | waiting for start with a non-empty queue
// WAIT_READY | waiting for busy=0 before issuing the queue head
// ISSUE      | cmd_valid high for one cycle, head popped
// HOLD       | guard cycle, busy ignored; choose next wait or finish
// WAIT_DONE  | write-out issued, waiting for done
// FINISH     | run complete, back to IDLE next cycle
module lcd_host #(
  parameter int CQ_DEPTH = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_we,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       cq_push,
  input  logic [3:0] cq_cmd,
  output logic       cq_full,
  input  logic       start,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  input  logic       IROM_rd,
  input  logic [5:0] IROM_A,
  output logic [7:0] IROM_Q,
  input  logic       IRAM_valid,
  input  logic [5:0] IRAM_A,
  input  logic [7:0] IRAM_D,
  input  logic [5:0] rb_addr,
  output logic [7:0] rb_data,
  output logic [6:0] cap_count,
  output logic       run_done,
  output logic       err
);

  localparam int AW = $clog2(CQ_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_READY, ISSUE, HOLD, WAIT_DONE, FINISH
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    store [64];
  logic [7:0]    fb    [64];
  logic [3:0]    cq_mem [CQ_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cq_count, cq_count_nxt;
  logic          push_ok, pop, cq_empty;
  logic [TW-1:0] timer;
  logic          timed_out, abort, start_ok;

  // Memories are never cleared so image and captured frame survive a reset.
  always_ff @(posedge clk) begin
    if (cfg_we) store[cfg_addr] <= cfg_data;
    if (IRAM_valid) fb[IRAM_A] <= IRAM_D;
    if (push_ok) cq_mem[wr_ptr] <= cq_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) IROM_Q <= '0;
    else if (IROM_rd) IROM_Q <= store[IROM_A];
  end

  assign rb_data = fb[rb_addr];

  assign cq_empty     = (cq_count == '0);
  assign push_ok      = cq_push & ~cq_full;
  assign pop          = (state == ISSUE);
  assign cq_count_nxt = cq_count + (AW+1)'(push_ok) - (AW+1)'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cq_count <= '0;
      cq_full  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cq_count <= cq_count_nxt;
      cq_full  <= (cq_count_nxt == (AW+1)'(CQ_DEPTH));
    end
  end

  assign start_ok  = (state == IDLE) && start && !cq_empty;
  assign timed_out = (timer == TW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      IDLE:       if (start_ok) state_nxt = WAIT_READY;
      WAIT_READY: begin
        if (!busy) state_nxt = ISSUE;
        else if (timed_out) begin
          state_nxt = FINISH;
          abort     = 1'b1;
        end
      end
      ISSUE:      state_nxt = HOLD;
      // cmd still holds the entry popped in ISSUE
      HOLD: begin
        if (cmd == 4'd0) state_nxt = WAIT_DONE;
        else if (!cq_empty) state_nxt = WAIT_READY;
        else state_nxt = FINISH;
      end
      WAIT_DONE: begin
        if (done) state_nxt = FINISH;
        else if (timed_out) begin
          state_nxt = FINISH;
          abort     = 1'b1;
        end
      end
      FINISH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      run_done  <= 1'b0;
      err       <= 1'b0;
      cap_count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) timer <= '0;
      else if (state == WAIT_READY || state == WAIT_DONE) timer <= timer + TW'(1);
      cmd_valid <= (state_nxt == ISSUE);
      if (state_nxt == ISSUE) cmd <= cq_mem[rd_ptr];
      if (start_ok) begin
        run_done <= 1'b0;
        err      <= 1'b0;
      end else if (state_nxt == FINISH && state != FINISH) begin
        run_done <= 1'b1;
        if (abort) err <= 1'b1;
      end
      if (start_ok) cap_count <= '0;
      else if (IRAM_valid && cap_count != 7'd127) cap_count <= cap_count + 7'd1;
    end
  end

endmodule

// File: doc/lcd_host.md
Name: lcd_host

Overview:
- Host-side counterpart of the LCD image controller.
- Serves the controller's IROM read requests from an internal 64x8 image store, which is preloaded through a config port.
- Issues a queued command stream over the cmd/cmd_valid/busy handshake.
- Captures the controller's IRAM write-back into a 64x8 frame buffer, readable through a readback port.
- Used as the system/bench-side driver and result collector for the controller.

Parameters:
- CQ_DEPTH, 16, command queue depth (power of two, >=2).
- TIMEOUT, 1023, max cycles spent in WAIT_READY or WAIT_DONE before the error abort.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  image-store write strobe.
- cfg_addr  in  6  image-store write address.
- cfg_data  in  8  image-store write data.
- cq_push  in  1  push cq_cmd into the command queue.
- cq_cmd  in  4  command code (0 write-out, 1-11 image ops).
- cq_full  out  1  queue full.
- start  in  1  one-cycle pulse to begin issuing.
- cmd  out  4  command to controller.
- cmd_valid  out  1  command strobe.
- busy  in  1  controller busy.
- done  in  1  controller write-out complete.
- IROM_rd  in  1  controller ROM read enable.
- IROM_A  in  6  controller ROM address.
- IROM_Q  out  8  ROM data.
- IRAM_valid  in  1  controller RAM write strobe.
- IRAM_A  in  6  RAM write address.
- IRAM_D  in  8  RAM write data.
- rb_addr  in  6  frame-buffer readback address.
- rb_data  out  8  frame-buffer data (combinational read).
- cap_count  out  7  IRAM beats captured, saturates at 127.
- run_done  out  1  sequence finished.
- err  out  1  timeout abort occurred.

Behaviour:
- Reset (reset=0, async):
  - cmd=0, cmd_valid=0, IROM_Q=0, cq_full=0, cap_count=0, run_done=0, err=0.
  - Queue emptied; FSM to IDLE.
  - Image store and frame buffer are not cleared.
  - Reset mid-run aborts immediately with no further cmd_valid.
- Image store:
  - cfg_we writes store[cfg_addr]<=cfg_data.
  - IROM responder: when IROM_rd=1 at an edge, IROM_Q<=store[IROM_A] (1-cycle latency); otherwise IROM_Q holds.
  - cfg_we and IROM_rd to the same address in the same cycle: IROM_Q returns the old data.
- Capture:
  - When IRAM_valid=1 at an edge, fb[IRAM_A]<=IRAM_D and cap_count increments, saturating at 127.
  - Capture is active in every state, including IDLE.
  - cap_count clears only on reset or on an accepted start.
- Command queue:
  - Synchronous FIFO, depth CQ_DEPTH.
  - Push while full is dropped (the queue is unchanged).
  - Push and pop in the same cycle are both honoured.
  - cq_full is registered, consistent with occupancy.
- FSM states: IDLE, WAIT_READY, ISSUE, HOLD, WAIT_DONE, FINISH.
  - IDLE: start with queue non-empty -> WAIT_READY; clears run_done, err and cap_count. start with the queue empty is ignored.
  - WAIT_READY: busy=0 -> ISSUE. Timer counts; reaching TIMEOUT -> FINISH with err=1.
  - ISSUE: cmd=queue head, cmd_valid=1 for exactly one cycle, head popped. -> HOLD.
  - HOLD: one guard cycle; busy is ignored, so a late busy rise is not mistaken for ready.
    - If the popped cmd was 0 -> WAIT_DONE.
    - Else if the queue is non-empty -> WAIT_READY.
    - Else -> FINISH.
  - WAIT_DONE: done=1 -> FINISH. Timer abort as in WAIT_READY.
  - FINISH: run_done=1 (level); -> IDLE next cycle, and run_done stays 1 until the next accepted start.
- Timer:
  - Width ceil(log2(TIMEOUT+1)).
  - Clears on every state entry.
- Queue contents:
  - Entries remaining after a write-out command stay queued for the next start.
  - Pushes during a run are allowed and are issued if they arrive before the queue drains.
- cmd holds its last value when cmd_valid=0.
- Consecutive cmd_valid pulses are separated by at least 2 cycles.

Test Plan:
- Preload store[i]=i, controller pulls all 64 addresses -> IROM_Q equals the previous cycle's IROM_A; a frame written back unmodified gives fb[i]=i, cap_count=64, run_done=1, err=0.
- Queue {4,5,0}, start while busy=1 for 10 cycles -> first cmd_valid in the cycle after busy falls, cmd=4; cmd_valid pulses are single-cycle with a >=2-cycle gap; cmd=0 issued last, then run_done rises the cycle after done.
- Push 17 commands with CQ_DEPTH=16 -> cq_full=1 after 16 pushes, 17th dropped; 16 cmd_valid pulses issued.
- busy held at 1 after start, TIMEOUT=1023 -> no cmd_valid; err=1 and run_done=1 1024 cycles after entering WAIT_READY.
- Queue {1,2} with no write-out -> two commands issued, run_done=1, and WAIT_DONE is never entered.
- Reset asserted during WAIT_DONE -> all outputs immediately return to reset values; fb contents preserved, and a readback after reset matches the previously captured data.
